// File: rtl/dsp_pkg.sv
// Shared types and 3x3 kernel tables for the multi-channel stream filter.
package dsp_pkg;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        SHARPEN = 2'd1,
        GAUSS   = 2'd2,
        EDGE    = 2'd3
    } mode_e;

    typedef logic signed [4:0] coef_t;
    // Row-major: index = row*3 + col, row 0 = top, col 0 = oldest column.
    typedef coef_t kern_t [9];

    localparam kern_t K_PASS    = '{5'sd0, 5'sd0, 5'sd0,
                                    5'sd0, 5'sd1, 5'sd0,
                                    5'sd0, 5'sd0, 5'sd0};
    localparam kern_t K_SHARPEN = '{5'sd0, -5'sd1, 5'sd0,
                                    -5'sd1, 5'sd5, -5'sd1,
                                    5'sd0, -5'sd1, 5'sd0};
    localparam kern_t K_GAUSS   = '{5'sd1, 5'sd2, 5'sd1,
                                    5'sd2, 5'sd4, 5'sd2,
                                    5'sd1, 5'sd2, 5'sd1};
    localparam kern_t K_EDGE    = '{-5'sd1, -5'sd1, -5'sd1,
                                    -5'sd1, 5'sd8, -5'sd1,
                                    -5'sd1, -5'sd1, -5'sd1};

    localparam int GAUSS_SHIFT = 4;
    localparam int GAUSS_RND   = 8;

    function automatic kern_t kernel(input mode_e m);
        case (m)
            PASS:    return K_PASS;
            SHARPEN: return K_SHARPEN;
            GAUSS:   return K_GAUSS;
            default: return K_EDGE;
        endcase
    endfunction

endpackage

// File: rtl/dsp_stream_nch_conv33_ch.sv
// One filtered channel: 3-column sliding window, 3x3 MAC and round/clamp output stage.
module conv33_ch
    import dsp_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int ACCW        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv,
    input  logic                   accept,
    input  mode_e                  mode_q,
    input  logic [PIXEL_WIDTH-1:0] top_s,
    input  logic [PIXEL_WIDTH-1:0] mid_s,
    input  logic [PIXEL_WIDTH-1:0] bot_s,
    output logic [PIXEL_WIDTH-1:0] pix_p2
);

    localparam logic signed [ACCW-1:0] RND  = ACCW'(GAUSS_RND);
    localparam logic signed [ACCW-1:0] MAXV = ACCW'((1 << PIXEL_WIDTH) - 1);

    logic [PIXEL_WIDTH-1:0] win [9];
    kern_t                  k;
    logic signed [ACCW-1:0] prod [9];
    logic signed [ACCW-1:0] acc_c;
    logic signed [ACCW-1:0] acc_p1;
    logic                   gauss_p1;

    function automatic logic [PIXEL_WIDTH-1:0] round_sat(input logic signed [ACCW-1:0] a,
                                                         input logic gauss);
        logic signed [ACCW-1:0] v;
        v = gauss ? (a + RND) >>> GAUSS_SHIFT : a;
        if (v[ACCW-1]) return '0;
        if (v > MAXV) return '1;
        return v[PIXEL_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= '{default: '0};
        end else if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= top_s;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= mid_s;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= bot_s;
        end
    end

    assign k = kernel(mode_q);

    for (genvar i = 0; i < 9; i++) begin : g_tap
        assign prod[i] = ACCW'(k[i]) * signed'({{(ACCW-PIXEL_WIDTH){1'b0}}, win[i]});
    end

    assign acc_c = prod[0] + prod[1] + prod[2] + prod[3] + prod[4]
                 + prod[5] + prod[6] + prod[7] + prod[8];

    // stage 1: accumulate; stage 2: round and clamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1   <= '0;
            gauss_p1 <= 1'b0;
            pix_p2   <= '0;
        end else if (adv) begin
            acc_p1   <= acc_c;
            gauss_p1 <= (mode_q == GAUSS);
            pix_p2   <= round_sat(acc_p1, gauss_p1);
        end
    end

endmodule

// File: rtl/dsp_stream_nch.sv
// NUM_CH-channel 3x3 stream filter with valid/ready handshake and optional alpha lane.
module dsp_stream_nch
    import dsp_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM_CH      = 4,
    parameter int ACCW        = 16,
    parameter bit ALPHA_EN    = 1'b1,
    parameter bit ALPHA_PASS  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          sol,
    input  logic [NUM_CH*PIXEL_WIDTH-1:0] top_pix,
    input  logic [NUM_CH*PIXEL_WIDTH-1:0] mid_pix,
    input  logic [NUM_CH*PIXEL_WIDTH-1:0] bot_pix,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*PIXEL_WIDTH-1:0] pixel_out
);

    localparam int NF = ALPHA_EN ? NUM_CH - 1 : NUM_CH;

    if (ACCW < PIXEL_WIDTH + 6) begin : g_accw_chk
        $error("ACCW must be at least PIXEL_WIDTH+6");
    end

    logic       adv;
    logic       accept;
    logic [1:0] col_cnt;
    logic [1:0] col_nxt;
    mode_e      mode_q;
    logic       vld_p0;
    logic       vld_p1;
    logic       vld_p2;

    assign adv       = !vld_p2 || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign out_valid = vld_p2;

    always_comb begin
        col_nxt = col_cnt;
        if (sol)                  col_nxt = 2'd1;
        else if (col_cnt != 2'd3) col_nxt = col_cnt + 2'd1;
    end

    // window-valid (p0), stage 1 (p1), output (p2)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= 2'd0;
            mode_q  <= PASS;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else if (adv) begin
            if (accept) begin
                col_cnt <= col_nxt;
                if (sol) mode_q <= mode_e'(mode);
            end
            vld_p0 <= accept && (col_nxt == 2'd3);
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    for (genvar ch = 0; ch < NF; ch++) begin : g_ch
        conv33_ch #(
            .PIXEL_WIDTH(PIXEL_WIDTH),
            .ACCW       (ACCW)
        ) u_conv (
            .clk   (clk),
            .rst   (rst),
            .adv   (adv),
            .accept(accept),
            .mode_q(mode_q),
            .top_s (top_pix[ch*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .mid_s (mid_pix[ch*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .bot_s (bot_pix[ch*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .pix_p2(pixel_out[ch*PIXEL_WIDTH +: PIXEL_WIDTH])
        );
    end

    if (ALPHA_EN) begin : g_alpha
        localparam int AL = (NUM_CH - 1) * PIXEL_WIDTH;
        logic [PIXEL_WIDTH-1:0] a_c0;
        logic [PIXEL_WIDTH-1:0] a_c1;
        logic [PIXEL_WIDTH-1:0] alpha_p1;
        logic [PIXEL_WIDTH-1:0] alpha_p2;
        // Only the mid-row alpha is ever forwarded; top/bottom alpha is deliberately dropped.
        logic                   unused_alpha_rows;

        assign unused_alpha_rows = ^{top_pix[AL +: PIXEL_WIDTH], bot_pix[AL +: PIXEL_WIDTH]};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_c0     <= '0;
                a_c1     <= '0;
                alpha_p1 <= '0;
                alpha_p2 <= '0;
            end else if (adv) begin
                if (accept) begin
                    a_c0 <= mid_pix[AL +: PIXEL_WIDTH];
                    a_c1 <= a_c0;
                end
                alpha_p1 <= ALPHA_PASS ? a_c1 : '1;
                alpha_p2 <= alpha_p1;
            end
        end

        assign pixel_out[AL +: PIXEL_WIDTH] = alpha_p2;
    end

endmodule

// File: tb/tb_dsp_stream_nch.sv
// Directed and randomized bench for dsp_stream_nch against a column-list reference model.
module tb_dsp_stream_nch;

    localparam int PW   = 8;
    localparam int NCH  = 4;
    localparam int ACCW = 16;
    localparam bit AEN  = 1'b1;
    localparam bit APAS = 1'b1;

    typedef logic [NCH*PW-1:0] word_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic       sol;
    word_t      top_pix, mid_pix, bot_pix;
    logic       out_valid;
    logic       out_ready;
    word_t      pixel_out;

    always #5 clk = ~clk;

    dsp_stream_nch #(
        .PIXEL_WIDTH(PW),
        .NUM_CH     (NCH),
        .ACCW       (ACCW),
        .ALPHA_EN   (AEN),
        .ALPHA_PASS (APAS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sol      (sol),
        .top_pix  (top_pix),
        .mid_pix  (mid_pix),
        .bot_pix  (bot_pix),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pixel_out(pixel_out)
    );

    int    errors = 0;
    int    checks = 0;
    word_t ct[$], cm[$], cb[$];
    word_t exp_q[$];
    int    row_cnt = 0;
    int    cur_mode = 0;
    word_t last_out = '0;
    int    out_cnt = 0;
    bit    rnd_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wt(input int md, input int dr, input int dc);
        int ad, ac;
        ad = (dr < 0) ? -dr : dr;
        ac = (dc < 0) ? -dc : dc;
        case (md)
            0:       return (ad + ac == 0) ? 1 : 0;
            1:       return (ad + ac == 0) ? 5 : ((ad + ac == 1) ? -1 : 0);
            2:       return (2 - ad) * (2 - ac);
            default: return (ad + ac == 0) ? 8 : -1;
        endcase
    endfunction

    function automatic word_t model_out(input int md);
        word_t r, w;
        int    s;
        r = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (AEN && ch == NCH - 1) begin
                w = cm[1];
                r[ch*PW +: PW] = APAS ? w[ch*PW +: PW] : '1;
            end else begin
                s = 0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++) begin
                        w = (dr == 0) ? ct[dc] : ((dr == 1) ? cm[dc] : cb[dc]);
                        s += wt(md, dr - 1, dc - 1) * int'(w[ch*PW +: PW]);
                    end
                if (md == 2) s = (s + 8) >>> 4;
                if (s < 0) s = 0;
                if (s > (1 << PW) - 1) s = (1 << PW) - 1;
                r[ch*PW +: PW] = PW'(s);
            end
        end
        return r;
    endfunction

    // Reference model: accepted beats build the current row's column list.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            if (sol) begin
                ct.delete(); cm.delete(); cb.delete();
                row_cnt = 0;
                cur_mode = int'(mode);
            end
            ct.push_back(top_pix); cm.push_back(mid_pix); cb.push_back(bot_pix);
            if (ct.size() > 3) begin
                void'(ct.pop_front()); void'(cm.pop_front()); void'(cb.pop_front());
            end
            if (row_cnt < 3) row_cnt++;
            if (row_cnt == 3) exp_q.push_back(model_out(cur_mode));
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("pixel", pixel_out, exp_q.pop_front());
            last_out = pixel_out;
            out_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    function automatic word_t splat(input logic [7:0] v);
        return {v, v, v, v};
    endfunction

    function automatic word_t px(input logic [7:0] a, input logic [7:0] c2,
                                 input logic [7:0] c1, input logic [7:0] c0);
        return {a, c2, c1, c0};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic s, input logic [1:0] m, input word_t t,
                        input word_t mm, input word_t b);
        int n;
        n = 0;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        in_valid = 1'b1; sol = s; mode = m;
        top_pix = t; mid_pix = mm; bot_pix = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("accept_wait", n < 100, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; sol = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic row_flat(input logic [1:0] m, input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send(i == 0, m, splat(v), splat(v), splat(v));
        drain();
    endtask

    int    base;
    word_t held;

    initial begin
        rst = 1'b1; in_valid = 1'b0; sol = 1'b0; mode = 2'd0;
        top_pix = '0; mid_pix = '0; bot_pix = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // pass row with latency check
        base = out_cnt;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] r;
            r = 8'(10 * (i + 1));
            send(i == 0, 2'd0, word_t'($urandom), px(8'h7F, r + 8'd2, r + 8'd1, r), word_t'($urandom));
            if (i == 2) chk("pass_lat_a", out_valid, 0);
            if (i == 3) chk("pass_lat_b", out_valid, 0);
            if (i == 4) begin
                chk("pass_lat_c", out_valid, 1);
                chk("pass_first", pixel_out, 32'h7F161514);
            end
        end
        drain();
        chk("pass_count", out_cnt - base, 3);
        chk("pass_last", last_out, 32'h7F2A2928);

        row_flat(2'd2, 8'd100, 4);
        chk("gauss_flat", last_out, 32'h64646464);
        row_flat(2'd3, 8'd100, 4);
        chk("edge_flat", last_out, 32'h64000000);

        send(1'b1, 2'd3, '0, '0, '0);
        send(1'b0, 2'd3, '0, px(8'h7F, 8'hFF, 8'hFF, 8'hFF), '0);
        send(1'b0, 2'd3, '0, '0, '0);
        drain();
        chk("edge_impulse", last_out, 32'h7FFFFFFF);

        send(1'b1, 2'd1, splat(8'd200), splat(8'd200), splat(8'd200));
        send(1'b0, 2'd1, splat(8'd200), px(8'h7F, 8'd0, 8'd0, 8'd0), splat(8'd200));
        send(1'b0, 2'd1, splat(8'd200), splat(8'd200), splat(8'd200));
        drain();
        chk("sharpen_neg_clamp", last_out, 32'h7F000000);

        // mode change without sol is ignored until the next row
        base = out_cnt;
        for (int i = 0; i < 6; i++)
            send(i == 0, (i < 3) ? 2'd1 : 2'd3, splat(8'd100), splat(8'd100), splat(8'd100));
        drain();
        chk("latch_count", out_cnt - base, 4);
        chk("latch_sharpen", last_out, 32'h64646464);
        row_flat(2'd3, 8'd100, 3);
        chk("latch_edge", last_out, 32'h64000000);

        // backpressure mid-row
        base = out_cnt;
        for (int i = 0; i < 4; i++)
            send(i == 0, 2'd2, word_t'($urandom), word_t'($urandom), word_t'($urandom));
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        held = pixel_out;
        in_valid = 1'b1; top_pix = word_t'($urandom); mid_pix = word_t'($urandom); bot_pix = word_t'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_pixel_hold", pixel_out, held);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(1'b0, 2'd0, top_pix, mid_pix, bot_pix);
        send(1'b0, 2'd0, word_t'($urandom), word_t'($urandom), word_t'($urandom));
        drain();
        chk("bp_count", out_cnt - base, 4);

        // reset mid-row, then non-sol beats after reset use pass mode
        for (int i = 0; i < 5; i++)
            send(i == 0, 2'd3, word_t'($urandom), word_t'($urandom), word_t'($urandom));
        chk("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_pixel_out", pixel_out, 0);
        exp_q.delete(); ct.delete(); cm.delete(); cb.delete();
        row_cnt = 0; cur_mode = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        base = out_cnt;
        for (int i = 0; i < 3; i++)
            send(1'b0, 2'd2, word_t'($urandom), px(8'h11, 8'h33, 8'h22, 8'(i)), word_t'($urandom));
        drain();
        chk("post_rst_count", out_cnt - base, 1);
        chk("post_rst_pass", last_out, 32'h11332201);

        // randomized rows with random backpressure, mid-row mode noise and stray sol beats
        rnd_ready = 1'b1;
        for (int r = 0; r < 30; r++) begin
            int         n;
            logic [1:0] m;
            n = $urandom_range(1, 8);
            m = 2'($urandom_range(0, 3));
            for (int b = 0; b < n; b++) begin
                word_t t, mm, bt;
                if ($urandom_range(0, 2) == 0) begin
                    t = splat(8'($urandom)); mm = word_t'($urandom); bt = splat(8'($urandom));
                end else begin
                    t = word_t'($urandom); mm = word_t'($urandom); bt = word_t'($urandom);
                end
                send((b == 0) || ($urandom_range(0, 9) == 0),
                     (b == 0) ? m : 2'($urandom_range(0, 3)), t, mm, bt);
            end
        end
        rnd_ready = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_stream_nch.md
Name: dsp_stream_nch

Overview:
- Parametrised successor of the fixed 3-channel RGB 3x3 filter stage.
- Takes three packed row words per beat (top/mid/bottom of one column) for NUM_CH channels.
- Runs a per-channel 3x3 kernel over a sliding 3-column window.
- Adds a valid/ready handshake, per-row window fill tracking, row-synchronous mode latching, and an optional alpha pass-through lane.
- Sits between the line-buffer reader and the framebuffer writer.

Parameters:
- PIXEL_WIDTH, 8, bits per channel sample (unsigned).
- NUM_CH, 4, channels per packed word; channel i occupies bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- ACCW, 16, signed accumulator width; must be >= PIXEL_WIDTH+6 (elaboration assertion).
- ALPHA_EN, 1
  - 1: channel NUM_CH-1 is alpha and is not filtered.
  - 0: all channels are filtered.
- ALPHA_PASS, 1
  - 1 (with ALPHA_EN=1): output alpha is the window-centre mid alpha.
  - 0: output alpha is all ones.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  0=pass, 1=sharpen, 2=gauss, 3=edge; sampled only on a sol beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready at the rising edge.
- sol  in  1  start-of-row; qualifies the accepted beat as column 0 of a new row.
- top_pix  in  NUM_CH*PIXEL_WIDTH  top-row column word.
- mid_pix  in  NUM_CH*PIXEL_WIDTH  mid-row column word.
- bot_pix  in  NUM_CH*PIXEL_WIDTH  bottom-row column word.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accept.
- pixel_out  out  NUM_CH*PIXEL_WIDTH  filtered packed pixel.

Behaviour:
- Reset (async, active-high): out_valid=0, pixel_out=0, col_cnt=0, mode_q=0 (pass), window and stage registers=0.
  - Reset asserted mid-row drops all in-flight data.
  - The first beat after reset must carry sol; non-sol beats are accepted and shift in but produce no output until col_cnt reaches 3.
- Advance enable: adv = !out_valid || out_ready; in_ready = adv.
  - When adv=0, every register (window, col_cnt, stage 1, output) holds.
- Window, per channel: three columns c2 (oldest), c1, c0 (newest), each holding top/mid/bottom.
  - On an accepted beat: c2<=c1, c1<=c0, c0<=input.
- col_cnt (2 bits, saturates at 3):
  - accepted sol beat: col_cnt<=1, mode_q<=mode.
  - other accepted beat: col_cnt<=min(col_cnt+1,3).
  - A mode change without sol is ignored until the next sol.
- Window valid (win_v):
  - Set on an accepted beat that leaves col_cnt==3 (i.e. the 3rd and later beats of a row).
  - A row of W beats yields W-2 outputs; the output column is the centre c1.
- Stage 1 (on adv): acc_i <= signed sum of kernel*window; s1_v <= win_v.
  - pass: centre only.
  - sharpen: centre 5; N, S, E, W -1; corners 0.
  - gauss: [1 2 1; 2 4 2; 1 2 1].
  - edge: centre 8; all 8 neighbours -1.
- Stage 2 (on adv): pixel_out, out_valid <= s1_v.
  - gauss: (acc+8)>>>4.
  - Other modes: no shift.
  - Then clamp to [0, 2^PIXEL_WIDTH-1].
- Latency: output registered 2 edges after the accepting edge of the window-completing beat; throughput 1 beat/cycle while out_ready=1.
- Alpha lane (ALPHA_EN=1): delayed alongside stages 1 and 2 without arithmetic.
  - ALPHA_PASS=1: value is c1 mid alpha.
  - ALPHA_PASS=0: value is all ones.
- Holding stalled output:
  - out_valid=1 && out_ready=0: pixel_out held stable, in_ready=0.
  - Simultaneous in_valid with out_ready=0 and out_valid=1: beat not accepted.
- A sol beat arriving mid-pipeline does not flush stages 1 and 2; previously completed windows still emerge.
- All arithmetic is signed ACCW; samples are zero-extended before multiply.

Decomposition:
- Package dsp_pkg holds:
  - mode_e enum (PASS, SHARPEN, GAUSS, EDGE).
  - 3x3 coefficient constant arrays per mode.
  - GAUSS_SHIFT=4 and GAUSS_RND=8.
- Sub-module conv33_ch (one per filtered channel, generate loop):
  - Contains the window, kernel MAC and stage-2 clamp.
  - Inputs: adv and accept, plus the shared mode_q.
- The top level owns the handshake, col_cnt, valid pipeline and alpha lane.

Test Plan:
- Pass: sol row of 5 beats, mid R=10,20,30,40,50 -> 3 outputs with R=20,30,40, first out_valid 2 cycles after the 3rd accept.
- Gauss: flat field 100 on all channels -> outputs 100.
- Edge:
  - Flat field 100 -> outputs 0.
  - Centre 255 with neighbours 0 -> outputs 255 (2040 clamped).
- Sharpen: centre 0 with neighbours 200 -> output 0 (negative clamp).
- Mode latching: mode changed 1->3 mid-row without sol -> remaining outputs still sharpen; next sol row uses edge.
- Backpressure: out_ready held low 5 cycles mid-row -> in_ready=0, pixel_out stable, no loss or duplication; 6-beat row yields exactly 4 outputs.
- Alpha (ALPHA_PASS=1): alpha 0x7F on centre -> alpha out 0x7F.
- Reset mid-row -> out_valid=0 immediately.
